interfaz_adc: RTL and testbench

- Front-end acquisition stage directly upstream of the 20 Hz high-pass biquad.
- Periodically reads a 12-bit serial ADC (ADCS7476-style: 4 leading zeros, then 12 data bits, MSB first) and converts the offset-binary code to signed Q10.14.
- Presents the result on `u` with a one-cycle `Enable` strobe, which directly drives the filter's `u`/`Enable` inputs.

---
 rtl/adc_pkg.sv | 25 ++
 rtl/divisor_muestreo.sv | 34 +++
 rtl/interfaz_adc.sv | 133 +++++++++++++
 tb/tb_interfaz_adc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - frame constants, FSM state codes and offset-binary conversion for interfaz_adc
package adc_pkg;

    localparam int LONG_TRAMA      = 16;
    localparam int CEROS_INICIALES = 4;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        PREPARA  = 3'd1,
        TRANSFER = 3'd2,
        CIERRE   = 3'd3,
        ENTREGA  = 3'd4
    } estado_t;

    // Drops the leading zeros, flips the offset-binary MSB into a sign bit and sign-extends.
    function automatic logic signed [LONG_TRAMA-1:0] a_con_signo(
        input logic [LONG_TRAMA-1:0] trama,
        input int                    bits
    );
        logic [LONG_TRAMA-1:0] alineado;
        alineado = (trama << (LONG_TRAMA - bits)) ^ {1'b1, {(LONG_TRAMA-1){1'b0}}};
        return $signed(alineado) >>> (LONG_TRAMA - bits);
    endfunction

endpackage

// File: rtl/divisor_muestreo.sv
// rtl/divisor_muestreo.sv - sample-period tick generator, cleared while sampling is disabled
module divisor_muestreo #(
    parameter int CICLOS_MUESTRA = 2000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic habilitar_i,
    output logic tick_o
);

    localparam int CW = (CICLOS_MUESTRA > 1) ? $clog2(CICLOS_MUESTRA) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_MUESTRA - 1);

    logic [CW-1:0] cuenta_q;
    logic          tick_q;

    // Tick is registered off the terminal count, so it lands CICLOS_MUESTRA cycles after enable.
    always_ff @(posedge clk_i) begin
        if (reset_i || !habilitar_i) begin
            cuenta_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= (cuenta_q == ULTIMO);
            if (cuenta_q == ULTIMO) begin
                cuenta_q <= '0;
            end else begin
                cuenta_q <= cuenta_q + CW'(1);
            end
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/interfaz_adc.sv
// rtl/interfaz_adc.sv - periodic serial ADC reader producing Q10.14 samples with a one-cycle strobe
module interfaz_adc
    import adc_pkg::*;
#(
    parameter int W              = 25,
    parameter int FRAC           = 14,
    parameter int ADC_BITS       = 12,
    parameter int SCLK_HALF      = 4,
    parameter int CICLOS_MUESTRA = 2000
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Habilitar,
    input  logic                SDATA,
    output logic                CS_n,
    output logic                SCLK,
    output logic signed [W-1:0] u,
    output logic                Enable,
    output logic                Err_trama,
    output logic                Sobrecarga
);

    localparam int DESPL = FRAC - ADC_BITS + 1;
    localparam int FW    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BW    = $clog2(LONG_TRAMA + 1);
    localparam logic [FW-1:0] FIN_FASE    = FW'(SCLK_HALF - 1);
    localparam logic [BW-1:0] ULTIMO_BIT  = BW'(LONG_TRAMA - 1);

    logic                   tick;
    estado_t                estado_q;
    logic [FW-1:0]          fase_q;
    logic [BW-1:0]          bits_q;
    logic [LONG_TRAMA-1:0]  shift_q;
    logic                   cs_n_q;
    logic                   sclk_q;
    logic signed [W-1:0]    u_q;
    logic signed [W-1:0]    u_d;
    logic signed [LONG_TRAMA-1:0] muestra_s;
    logic                   enable_q;
    logic                   err_q;
    logic                   sobre_q;

    divisor_muestreo #(
        .CICLOS_MUESTRA(CICLOS_MUESTRA)
    ) u_divisor (
        .clk_i      (CLK),
        .reset_i    (Reset),
        .habilitar_i(Habilitar),
        .tick_o     (tick)
    );

    always_comb begin
        muestra_s = a_con_signo(shift_q, ADC_BITS);
        u_d       = W'(muestra_s) <<< DESPL;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            estado_q <= REPOSO;
            fase_q   <= '0;
            bits_q   <= '0;
            shift_q  <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            u_q      <= '0;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
            sobre_q  <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            if (tick && estado_q != REPOSO) begin
                sobre_q <= 1'b1;
            end
            case (estado_q)
                REPOSO: begin
                    if (tick) begin
                        estado_q <= PREPARA;
                        cs_n_q   <= 1'b0;
                        fase_q   <= '0;
                    end
                end
                PREPARA: begin
                    if (fase_q == FIN_FASE) begin
                        estado_q <= TRANSFER;
                        sclk_q   <= 1'b0;
                        fase_q   <= '0;
                        bits_q   <= '0;
                    end else begin
                        fase_q <= fase_q + FW'(1);
                    end
                end
                TRANSFER: begin
                    // First cycle of each high half is the one in which SCLK rose.
                    if (sclk_q && fase_q == '0) begin
                        shift_q <= {shift_q[LONG_TRAMA-2:0], SDATA};
                        bits_q  <= bits_q + BW'(1);
                    end
                    if (sclk_q && fase_q == '0 && bits_q == ULTIMO_BIT) begin
                        estado_q <= CIERRE;
                        cs_n_q   <= 1'b1;
                    end else if (fase_q == FIN_FASE) begin
                        sclk_q <= ~sclk_q;
                        fase_q <= '0;
                    end else begin
                        fase_q <= fase_q + FW'(1);
                    end
                end
                CIERRE: begin
                    u_q      <= u_d;
                    enable_q <= 1'b1;
                    if (shift_q[LONG_TRAMA-1 -: CEROS_INICIALES] != '0) begin
                        err_q <= 1'b1;
                    end
                    estado_q <= ENTREGA;
                end
                ENTREGA: begin
                    estado_q <= REPOSO;
                end
                default: begin
                    estado_q <= REPOSO;
                end
            endcase
        end
    end

    assign CS_n       = cs_n_q;
    assign SCLK       = sclk_q;
    assign u          = u_q;
    assign Enable     = enable_q;
    assign Err_trama  = err_q;
    assign Sobrecarga = sobre_q;

endmodule

// File: tb/tb_interfaz_adc.sv
// tb/tb_interfaz_adc.sv - self-checking bench for interfaz_adc with an ADC model and sample scoreboard
module tb_interfaz_adc;

    logic        clk = 1'b0;
    logic        rst, hab, sdata;
    logic        cs_n, sclk, en, err, sob;
    logic [24:0] u;
    logic        rst2, hab2, sdata2;
    logic        cs2, sclk2, en2, err2, sob2;
    logic [24:0] u2;

    logic [15:0] adc_word  = 16'h0800;
    logic [15:0] adc_word2 = 16'h0FFF;
    int          fall_cnt  = 0;
    int          fall_cnt2 = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interfaz_adc dut (
        .CLK(clk), .Reset(rst), .Habilitar(hab), .SDATA(sdata),
        .CS_n(cs_n), .SCLK(sclk), .u(u), .Enable(en),
        .Err_trama(err), .Sobrecarga(sob)
    );

    interfaz_adc #(.CICLOS_MUESTRA(100)) dut_ov (
        .CLK(clk), .Reset(rst2), .Habilitar(hab2), .SDATA(sdata2),
        .CS_n(cs2), .SCLK(sclk2), .u(u2), .Enable(en2),
        .Err_trama(err2), .Sobrecarga(sob2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic logic [24:0] modelo_u(input logic [15:0] w);
        int v;
        v = (int'(w[11:0]) - 2048) * 8;
        return v[24:0];
    endfunction

    // ADC: first bit appears when CS falls, each later bit on an SCLK falling edge.
    always @(negedge cs_n or negedge sclk) begin
        if (sclk) begin
            fall_cnt = 0;
            sdata = adc_word[15];
        end else if (!cs_n && fall_cnt < 16) begin
            fall_cnt++;
            sdata = adc_word[16 - fall_cnt];
        end
    end

    always @(negedge cs2 or negedge sclk2) begin
        if (sclk2) begin
            fall_cnt2 = 0;
            sdata2 = adc_word2[15];
        end else if (!cs2 && fall_cnt2 < 16) begin
            fall_cnt2++;
            sdata2 = adc_word2[16 - fall_cnt2];
        end
    end

    logic rst_smp = 1'b1, rst2_smp = 1'b1, vivo = 1'b0;
    always @(posedge clk) begin
        rst_smp  <= rst;
        rst2_smp <= rst2;
        vivo     <= 1'b1;
    end

    logic [24:0] exp_u[$];
    logic        exp_e[$];
    logic [24:0] u_mod = '0;
    logic        err_exp = 1'b0;
    logic        pend = 1'b0;
    logic        en_esp;
    logic        cs_prev = 1'b1, sclk_prev = 1'b1;
    logic [15:0] frame_word = '0;
    int          low_cnt = 0, rises = 0, last_low = 0, last_rises = 0;

    always @(negedge clk) begin
        if (vivo) begin
            if (rst_smp) begin
                chk("rst_cs_n", cs_n, 1);
                chk("rst_sclk", sclk, 1);
                chk("rst_u", u, 0);
                chk("rst_enable", en, 0);
                chk("rst_err", err, 0);
                chk("rst_sobre", sob, 0);
                exp_u.delete();
                exp_e.delete();
                u_mod = '0;
                err_exp = 1'b0;
                pend = 1'b0;
                low_cnt = 0;
                rises = 0;
            end else begin
                en_esp = pend;
                pend = 1'b0;
                if (!cs_n) begin
                    low_cnt++;
                    if (sclk && !sclk_prev) rises++;
                end
                if (!cs_n && cs_prev) frame_word = adc_word;
                if (cs_n && !cs_prev) begin
                    chk("cs_bajo", low_cnt, 129);
                    chk("flancos", rises, 16);
                    last_low = low_cnt;
                    last_rises = rises;
                    exp_u.push_back(modelo_u(frame_word));
                    exp_e.push_back(frame_word[15:12] != 4'h0);
                    pend = 1'b1;
                    low_cnt = 0;
                    rises = 0;
                end
                chk("enable", en, en_esp);
                if (en && exp_u.size() != 0) begin
                    u_mod = exp_u.pop_front();
                    err_exp = err_exp | exp_e.pop_front();
                end
                chk("u", u, u_mod);
                chk("err_trama", err, err_exp);
            end
        end
        cs_prev = cs_n;
        sclk_prev = sclk;
    end

    int cyc2 = 0, last2 = -1, n_ov = 0, low2 = 0;
    logic cs2_prev = 1'b1;
    always @(negedge clk) begin
        if (vivo && !rst2_smp) begin
            cyc2++;
            if (!cs2) low2++;
            if (cs2 && !cs2_prev) begin
                chk("ov_cs_bajo", low2, 129);
                low2 = 0;
            end
            if (en2) begin
                chk("ov_u", u2, 25'h0003FF8);
                chk("ov_err", err2, 0);
                if (last2 >= 0) chk("ov_periodo", cyc2 - last2, 200);
                last2 = cyc2;
                n_ov++;
            end
        end
        cs2_prev = cs2;
    end

    task automatic wait_enable(input int bound, output int n);
        bit hallado;
        hallado = 1'b0;
        n = 0;
        while (!hallado && n < bound) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (en) hallado = 1'b1;
        end
        if (!hallado) n = -1;
    endtask

    logic [15:0] cods[3] = '{16'h0FFF, 16'h0000, 16'h07FF};
    logic [24:0] us[3]   = '{25'h0003FF8, 25'h1FFC000, 25'h1FFFFF8};

    initial begin
        int n, r, k, act;
        logic sp;
        rst = 1'b1; rst2 = 1'b1; hab = 1'b0; hab2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst2 = 1'b0; hab2 = 1'b1;
        @(posedge clk);
        #1 hab = 1'b1;
        wait_enable(2500, n);
        chk("lat_primera", n, 2131);
        chk("u_0800", u, 25'h0000000);
        chk("cs_129", last_low, 129);
        chk("flancos_16", last_rises, 16);

        for (int i = 0; i < 3; i++) begin
            adc_word = cods[i];
            wait_enable(2500, n);
            chk("periodo", n, 2000);
            chk("u_codigo", u, us[i]);
        end

        adc_word = 16'h2ABC;
        wait_enable(2500, n);
        chk("u_2abc", u, 25'h00015E0);
        chk("err_puesto", err, 1);
        adc_word = 16'h0800;
        wait_enable(2500, n);
        chk("u_limpia", u, 25'h0000000);
        chk("err_pegajoso", err, 1);

        adc_word = 16'h0555;
        r = 0; k = 0; sp = 1'b1;
        while (r < 8 && k < 3000) begin
            @(negedge clk);
            k++;
            if (!cs_n && sclk && !sp) r++;
            sp = sclk;
        end
        chk("flanco8_hallado", r, 8);
        rst = 1'b1;
        adc_word = 16'h0123;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 1);
        chk("abort_u", u, 0);
        chk("abort_enable", en, 0);
        wait_enable(2500, n);
        chk("lat_tras_reset", n, 2131);
        chk("u_0123", u, 25'h1FFC918);

        adc_word = 16'h0C00;
        k = 0;
        while (cs_n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 hab = 1'b0;
        wait_enable(300, n);
        chk("lat_hab_off", n, 129);
        chk("u_0c00", u, 25'h0002000);
        act = 0;
        repeat (2500) begin
            @(negedge clk);
            if (!cs_n || en) act++;
        end
        chk("sin_actividad", act, 0);
        adc_word = 16'h0400;
        @(posedge clk);
        #1 hab = 1'b1;
        wait_enable(2500, n);
        chk("lat_rehab", n, 2131);
        chk("u_0400", u, 25'h1FFE000);

        chk("sobre_principal", sob, 0);
        chk("sobre_ov", sob2, 1);
        chk("err_ov", err2, 0);
        chk("ov_tramas", n_ov >= 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
